// File: rtl/pdm_audio_ir_core.sv
// Stereo PDM audio modulator/demodulator plus a carrier-keyed IR frame receiver.
// Slow async clocks are synchronized and handled as one-clk edge events in the clk domain.
module pdm_audio_ir_core #(
    parameter int WIN     = 64,
    parameter int IR_BITS = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               aud_ock,
    input  logic [31:0]        aud_din_l,
    input  logic [31:0]        aud_din_r,
    output logic               aud_sdo,
    input  logic               aud_sdi,
    output logic [31:0]        aud_dout_l,
    output logic [31:0]        aud_dout_r,
    input  logic               ir_ock,
    input  logic               ir_bck,
    input  logic               ir_sdi,
    input  logic               ir_load,
    output logic               ir_done,
    output logic [IR_BITS-1:0] ir_dout
);

    localparam int LW = $clog2(WIN);
    localparam int IW = $clog2(IR_BITS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(IR_BITS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RX   = 2'd2;

    // Bit order: aud_ock, ir_ock, ir_bck, ir_sdi, aud_sdi (aud_sdi needs no edge history)
    logic [4:0] sync1_r;
    logic [4:0] sync2_r;
    logic [3:0] prev_r;

    logic aud_rise_s;
    logic aud_fall_s;
    logic ir_ock_rise_s;
    logic ir_bck_rise_s;
    logic ir_sdi_rise_s;
    logic aud_sdi_s;

    logic [31:0] acc_l_r;
    logic [31:0] acc_r_r;
    logic [32:0] sum_l_s;
    logic [32:0] sum_r_s;

    logic [WIN-1:0] sr_l_r;
    logic [WIN-1:0] sr_r_r;
    logic [LW:0]    cnt_l_r;
    logic [LW:0]    cnt_r_r;
    logic           upd_l_r;
    logic           upd_r_r;

    logic [1:0]         state_r;
    logic [7:0]         e_cnt_r;
    logic [7:0]         c_cnt_r;
    logic [IW-1:0]      bit_idx_r;
    logic [IR_BITS-2:0] hold_r;
    logic               slot_bit_s;
    logic [IR_BITS-1:0] next_hold_s;

    // Ones-count to 32-bit offset-binary level; a full window saturates to all ones.
    function automatic logic [31:0] scale_count(input logic [LW:0] c);
        if (c[LW]) begin
            return 32'hFFFF_FFFF;
        end else begin
            return {c[LW-1:0], {(32-LW){1'b0}}};
        end
    endfunction

    // Two-stage synchronizers plus edge history.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 5'b0_0000;
            sync2_r <= 5'b0_0000;
            prev_r  <= 4'b0000;
        end else begin
            sync1_r <= {aud_ock, ir_ock, ir_bck, ir_sdi, aud_sdi};
            sync2_r <= sync1_r;
            prev_r  <= sync2_r[4:1];
        end
    end

    assign aud_rise_s    =  sync2_r[4] & ~prev_r[3];
    assign aud_fall_s    = ~sync2_r[4] &  prev_r[3];
    assign ir_ock_rise_s =  sync2_r[3] & ~prev_r[2];
    assign ir_bck_rise_s =  sync2_r[2] & ~prev_r[1];
    assign ir_sdi_rise_s =  sync2_r[1] & ~prev_r[0];
    assign aud_sdi_s     =  sync2_r[0];

    assign sum_l_s = {1'b0, acc_l_r} + {1'b0, aud_din_l};
    assign sum_r_s = {1'b0, acc_r_r} + {1'b0, aud_din_r};

    // First-order delta-sigma: left on aud_ock rise, right on fall, carry is the PDM bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_l_r <= 32'h0000_0000;
            acc_r_r <= 32'h0000_0000;
            aud_sdo <= 1'b0;
        end else if (aud_rise_s) begin
            acc_l_r <= sum_l_s[31:0];
            aud_sdo <= sum_l_s[32];
        end else if (aud_fall_s) begin
            acc_r_r <= sum_r_s[31:0];
            aud_sdo <= sum_r_s[32];
        end
    end

    // Boxcar demodulator: sliding window ones-count, output refreshed one clk after capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_l_r     <= '0;
            sr_r_r     <= '0;
            cnt_l_r    <= '0;
            cnt_r_r    <= '0;
            upd_l_r    <= 1'b0;
            upd_r_r    <= 1'b0;
            aud_dout_l <= 32'h0000_0000;
            aud_dout_r <= 32'h0000_0000;
        end else begin
            upd_l_r <= 1'b0;
            upd_r_r <= 1'b0;
            if (aud_fall_s) begin
                sr_l_r  <= {sr_l_r[WIN-2:0], aud_sdi_s};
                cnt_l_r <= cnt_l_r + {{LW{1'b0}}, aud_sdi_s} - {{LW{1'b0}}, sr_l_r[WIN-1]};
                upd_l_r <= 1'b1;
            end
            if (aud_rise_s) begin
                sr_r_r  <= {sr_r_r[WIN-2:0], aud_sdi_s};
                cnt_r_r <= cnt_r_r + {{LW{1'b0}}, aud_sdi_s} - {{LW{1'b0}}, sr_r_r[WIN-1]};
                upd_r_r <= 1'b1;
            end
            if (upd_l_r) begin
                aud_dout_l <= scale_count(cnt_l_r);
            end
            if (upd_r_r) begin
                aud_dout_r <= scale_count(cnt_r_r);
            end
        end
    end

    // A slot reads as 1 when keyed edges reach a quarter of the carrier reference.
    assign slot_bit_s  = ({e_cnt_r, 2'b00} >= {2'b00, c_cnt_r}) && (e_cnt_r != 8'd0);
    assign next_hold_s = {hold_r, slot_bit_s};

    // IR receiver: IDLE waits for load, WAIT aligns to a slot boundary, RX collects IR_BITS slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            ir_done   <= 1'b0;
            ir_dout   <= '0;
            hold_r    <= '0;
            bit_idx_r <= '0;
            e_cnt_r   <= 8'd0;
            c_cnt_r   <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ir_load) begin
                        state_r <= ST_WAIT;
                        ir_done <= 1'b0;
                    end else begin
                        ir_done <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (ir_bck_rise_s) begin
                        state_r   <= ST_RX;
                        bit_idx_r <= '0;
                        e_cnt_r   <= 8'd0;
                        c_cnt_r   <= 8'd0;
                        hold_r    <= '0;
                    end
                end
                ST_RX: begin
                    if (ir_bck_rise_s) begin
                        hold_r    <= next_hold_s[IR_BITS-2:0];
                        e_cnt_r   <= 8'd0;
                        c_cnt_r   <= 8'd0;
                        bit_idx_r <= bit_idx_r + IW'(1);
                        if (bit_idx_r == LAST_IDX) begin
                            ir_dout <= next_hold_s;
                            state_r <= ST_IDLE;
                            ir_done <= 1'b1;
                        end
                    end else begin
                        if (ir_sdi_rise_s && (e_cnt_r != 8'hFF)) begin
                            e_cnt_r <= e_cnt_r + 8'd1;
                        end
                        if (ir_ock_rise_s && (c_cnt_r != 8'hFF)) begin
                            c_cnt_r <= c_cnt_r + 8'd1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ir_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pdm_audio_ir_core.sv
// Directed self-checking bench for pdm_audio_ir_core: PDM loopback levels, clock freeze,
// IR frame reception, back-to-back frames and reset in the middle of a frame.
module tb_pdm_audio_ir_core;

    localparam int WIN     = 64;
    localparam int IR_BITS = 5;

    logic               clk;
    logic               rst;
    logic               aud_ock;
    logic [31:0]        aud_din_l;
    logic [31:0]        aud_din_r;
    logic               aud_sdo;
    logic               aud_sdi;
    logic [31:0]        aud_dout_l;
    logic [31:0]        aud_dout_r;
    logic               ir_ock;
    logic               ir_bck;
    logic               ir_sdi;
    logic               ir_load;
    logic               ir_done;
    logic [IR_BITS-1:0] ir_dout;

    logic ir_gate;
    logic tie_load;
    logic load_man;

    int errors;
    int checks;

    assign aud_sdi = aud_sdo;
    assign ir_sdi  = ir_ock & ir_gate;
    assign ir_load = tie_load ? ir_done : load_man;

    pdm_audio_ir_core #(.WIN(WIN), .IR_BITS(IR_BITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .aud_ock    (aud_ock),
        .aud_din_l  (aud_din_l),
        .aud_din_r  (aud_din_r),
        .aud_sdo    (aud_sdo),
        .aud_sdi    (aud_sdi),
        .aud_dout_l (aud_dout_l),
        .aud_dout_r (aud_dout_r),
        .ir_ock     (ir_ock),
        .ir_bck     (ir_bck),
        .ir_sdi     (ir_sdi),
        .ir_load    (ir_load),
        .ir_done    (ir_done),
        .ir_dout    (ir_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        ir_ock = 1'b0;
        forever #40 ir_ock = ~ir_ock;
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One aud_ock period is 16 clk: 8 high, 8 low.
    task automatic aud_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            aud_ock = 1'b1;
            repeat (8) @(negedge clk);
            aud_ock = 1'b0;
            repeat (8) @(negedge clk);
        end
    endtask

    // Drives IR_BITS+1 ir_bck rises (start + one per slot), 64 clk per slot.
    task automatic ir_frame(input logic [IR_BITS-1:0] bits, output logic got_done,
                            output logic [IR_BITS-1:0] got_dout, output logic done_after,
                            output logic mid_done);
        int done_k;
        got_done   = 1'b0;
        got_dout   = '0;
        done_after = 1'bx;
        mid_done   = 1'bx;
        done_k     = -10;
        for (int s = 0; s <= IR_BITS; s++) begin
            ir_bck  = 1'b1;
            ir_gate = (s < IR_BITS) ? bits[IR_BITS-1-s] : 1'b0;
            if (s == IR_BITS) begin
                for (int k = 0; k < 32; k++) begin
                    @(negedge clk);
                    if (got_done && (k == done_k + 1)) done_after = ir_done;
                    if (!got_done && ir_done) begin
                        got_done = 1'b1;
                        got_dout = ir_dout;
                        done_k   = k;
                    end
                end
            end else begin
                repeat (16) @(negedge clk);
                if (s == 2) mid_done = ir_done;
                repeat (16) @(negedge clk);
            end
            ir_bck = 1'b0;
            repeat (32) @(negedge clk);
        end
        ir_gate = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (aud_sdo !== 1'b0) begin errors++; $display("FAIL reset_sdo: got %b expected 0", aud_sdo); end
        checks++; if (aud_dout_l !== 32'h0) begin errors++; $display("FAIL reset_dout_l: got %h expected 00000000", aud_dout_l); end
        checks++; if (aud_dout_r !== 32'h0) begin errors++; $display("FAIL reset_dout_r: got %h expected 00000000", aud_dout_r); end
        checks++; if (ir_dout !== 5'b00000) begin errors++; $display("FAIL reset_ir_dout: got %b expected 00000", ir_dout); end
        checks++; if (ir_done !== 1'b0) begin errors++; $display("FAIL reset_ir_done: got %b expected 0", ir_done); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ir_done !== 1'b1) begin errors++; $display("FAIL release_ir_done: got %b expected 1", ir_done); end
    endtask

    task automatic test_mod_midscale();
        do_reset();
        aud_din_l = 32'h8000_0000;
        aud_din_r = 32'h8000_0000;
        aud_cycles(4);
        // left 0,1,0,1 -> 2 ones; right has the reset 0 first: 0,0,1,0 -> 1 one
        checks++; if (aud_sdo !== 1'b1) begin errors++; $display("FAIL mid_sdo4: got %b expected 1", aud_sdo); end
        checks++; if (aud_dout_l !== 32'h0800_0000) begin errors++; $display("FAIL mid_l4: got %h expected 08000000", aud_dout_l); end
        checks++; if (aud_dout_r !== 32'h0400_0000) begin errors++; $display("FAIL mid_r4: got %h expected 04000000", aud_dout_r); end
        aud_cycles(128);
        checks++; if (aud_dout_l !== 32'h8000_0000) begin errors++; $display("FAIL mid_l: got %h expected 80000000", aud_dout_l); end
        checks++; if (aud_dout_r !== 32'h8000_0000) begin errors++; $display("FAIL mid_r: got %h expected 80000000", aud_dout_r); end
    endtask

    task automatic test_mod_fullscale();
        do_reset();
        aud_din_l = 32'hFFFF_FFFF;
        aud_din_r = 32'h0000_0000;
        aud_cycles(WIN);
        checks++; if (aud_dout_l !== 32'hFC00_0000) begin errors++; $display("FAIL full_l63: got %h expected fc000000", aud_dout_l); end
        checks++; if (aud_dout_r !== 32'h0) begin errors++; $display("FAIL full_r63: got %h expected 00000000", aud_dout_r); end
        aud_cycles(1);
        checks++; if (aud_dout_l !== 32'hFFFF_FFFF) begin errors++; $display("FAIL full_l_sat: got %h expected ffffffff", aud_dout_l); end
        checks++; if (aud_dout_r !== 32'h0) begin errors++; $display("FAIL full_r: got %h expected 00000000", aud_dout_r); end
        checks++; if (aud_sdo !== 1'b0) begin errors++; $display("FAIL full_sdo: got %b expected 0", aud_sdo); end
        aud_cycles(3);
        checks++; if (aud_dout_l !== 32'hFFFF_FFFF) begin errors++; $display("FAIL full_l_hold: got %h expected ffffffff", aud_dout_l); end
    endtask

    task automatic test_aud_freeze();
        do_reset();
        aud_din_l = 32'h4000_0000;
        aud_din_r = 32'hC000_0000;
        aud_cycles(6);
        checks++; if (aud_dout_l !== 32'h0400_0000) begin errors++; $display("FAIL frz_l_pre: got %h expected 04000000", aud_dout_l); end
        checks++; if (aud_dout_r !== 32'h0C00_0000) begin errors++; $display("FAIL frz_r_pre: got %h expected 0c000000", aud_dout_r); end
        checks++; if (aud_sdo !== 1'b1) begin errors++; $display("FAIL frz_sdo_pre: got %b expected 1", aud_sdo); end
        repeat (2000) @(negedge clk);
        checks++; if (aud_dout_l !== 32'h0400_0000) begin errors++; $display("FAIL frz_l_hold: got %h expected 04000000", aud_dout_l); end
        checks++; if (aud_dout_r !== 32'h0C00_0000) begin errors++; $display("FAIL frz_r_hold: got %h expected 0c000000", aud_dout_r); end
        checks++; if (aud_sdo !== 1'b1) begin errors++; $display("FAIL frz_sdo_hold: got %b expected 1", aud_sdo); end
        aud_cycles(6);
        checks++; if (aud_dout_l !== 32'h0C00_0000) begin errors++; $display("FAIL frz_l_resume: got %h expected 0c000000", aud_dout_l); end
        checks++; if (aud_dout_r !== 32'h2000_0000) begin errors++; $display("FAIL frz_r_resume: got %h expected 20000000", aud_dout_r); end
        checks++; if (aud_sdo !== 1'b1) begin errors++; $display("FAIL frz_sdo_resume: got %b expected 1", aud_sdo); end
    endtask

    task automatic test_ir_frame();
        logic gd, da, md;
        logic [IR_BITS-1:0] gv;
        checks++; if (ir_done !== 1'b1) begin errors++; $display("FAIL ir_idle: got %b expected 1", ir_done); end
        tie_load = 1'b1;
        repeat (4) @(negedge clk);
        ir_frame(5'b10110, gd, gv, da, md);
        checks++; if (gd !== 1'b1) begin errors++; $display("FAIL ir1_done_seen: got %b expected 1", gd); end
        checks++; if (gv !== 5'b10110) begin errors++; $display("FAIL ir1_dout: got %b expected 10110", gv); end
        checks++; if (md !== 1'b0) begin errors++; $display("FAIL ir1_busy: got %b expected 0", md); end
        checks++; if (da !== 1'b0) begin errors++; $display("FAIL ir1_reload: got %b expected 0", da); end
        ir_frame(5'b01001, gd, gv, da, md);
        checks++; if (gd !== 1'b1) begin errors++; $display("FAIL ir2_done_seen: got %b expected 1", gd); end
        checks++; if (gv !== 5'b01001) begin errors++; $display("FAIL ir2_dout: got %b expected 01001", gv); end
        tie_load = 1'b0;
    endtask

    task automatic test_ir_reset_midframe();
        logic gd, da, md;
        logic [IR_BITS-1:0] gv;
        logic [IR_BITS-1:0] bits;
        bits = 5'b11011;
        // receiver is already in WAIT from the tied-load run
        for (int s = 0; s < 3; s++) begin
            ir_bck  = 1'b1;
            ir_gate = bits[IR_BITS-1-s];
            repeat (16) @(negedge clk);
            if (s == 2) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                checks++; if (ir_dout !== 5'b00000) begin errors++; $display("FAIL abort_dout_rst: got %b expected 00000", ir_dout); end
                checks++; if (ir_done !== 1'b0) begin errors++; $display("FAIL abort_done_rst: got %b expected 0", ir_done); end
                rst = 1'b0;
                @(negedge clk);
                checks++; if (ir_done !== 1'b1) begin errors++; $display("FAIL abort_done_rel: got %b expected 1", ir_done); end
            end
            repeat (16) @(negedge clk);
            ir_bck = 1'b0;
            repeat (32) @(negedge clk);
        end
        ir_gate = 1'b0;
        checks++; if (ir_dout !== 5'b00000) begin errors++; $display("FAIL abort_dout_after: got %b expected 00000", ir_dout); end
        load_man = 1'b1;
        @(negedge clk);
        load_man = 1'b0;
        repeat (3) @(negedge clk);
        ir_frame(5'b01101, gd, gv, da, md);
        checks++; if (gd !== 1'b1) begin errors++; $display("FAIL ir3_done_seen: got %b expected 1", gd); end
        checks++; if (gv !== 5'b01101) begin errors++; $display("FAIL ir3_dout: got %b expected 01101", gv); end
        checks++; if (da !== 1'b1) begin errors++; $display("FAIL ir3_stay_idle: got %b expected 1", da); end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        aud_ock   = 1'b0;
        aud_din_l = 32'h0;
        aud_din_r = 32'h0;
        ir_bck    = 1'b0;
        ir_gate   = 1'b0;
        tie_load  = 1'b0;
        load_man  = 1'b0;
        @(negedge clk);
        test_reset();
        test_mod_midscale();
        test_mod_fullscale();
        test_aud_freeze();
        test_ir_frame();
        test_ir_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pdm_audio_ir_core.md
PDM_AUDIO_IR_CORE -- requirements
Module: pdm_audio_ir_core

Interface
REQ-001 Parameter WIN, 64, audio decimation window length in PDM bits per channel (power of two, 8..256).
REQ-002 Parameter IR_BITS, 5, IR frame length in bits.
REQ-003 Port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port aud_ock  input  1  audio PDM bit clock, asynchronous to clk, period >= 4 clk periods.
REQ-006 Port aud_din_l / aud_din_r  input  32 each  left/right audio samples, offset binary, midscale 0x80000000.
REQ-007 Port aud_sdo  output  1  stereo PDM stream out.
REQ-008 Port aud_sdi  input  1  stereo PDM stream in.
REQ-009 Port aud_dout_l / aud_dout_r  output  32 each  demodulated left/right samples, offset binary.
REQ-010 Port ir_ock  input  1  IR carrier reference clock, asynchronous, period >= 4 clk periods.
REQ-011 Port ir_bck  input  1  IR bit-slot clock, asynchronous, slower than ir_ock.
REQ-012 Port ir_sdi  input  1  IR carrier-keyed serial input.
REQ-013 Port ir_load  input  1  start-of-frame request, sampled per clk.
REQ-014 Port ir_done  output  1  high = IR receiver idle/ready and ir_dout valid.
REQ-015 Port ir_dout  output  IR_BITS  last received IR frame.

Function
REQ-016 aud_ock, ir_ock, ir_bck, aud_sdi, ir_sdi each pass through a 2-FF synchronizer; edge events are one-clk pulses from the synchronized value vs its previous value.
REQ-017 Modulator: on each aud_ock rising event, acc_l (33-bit) <= acc_l[31:0] + aud_din_l and aud_sdo <= carry (bit 32) in the same clk.
REQ-018 Modulator: on each aud_ock falling event, acc_r likewise accumulates aud_din_r and aud_sdo <= its carry; aud_sdo holds between events.
REQ-019 Demodulator: left bit = synchronized aud_sdi sampled at aud_ock falling event; right bit = sampled at aud_ock rising event.
REQ-020 Per channel, a WIN-deep shift register plus running ones-count (0..WIN) updates on every captured bit: count += new - oldest.
REQ-021 aud_dout_x updates on the clk after each captured bit: count scaled to 32 bits (count << (32-log2 WIN)); count == WIN saturates to 0xFFFFFFFF.
REQ-022 IR receiver states IDLE, WAIT, RX. IDLE: ir_done=1; ir_load=1 -> WAIT, ir_done=0 next clk.
REQ-023 WAIT: on next ir_bck rising event -> RX, clear bit index and slot counters.
REQ-024 RX: per slot, count synchronized ir_sdi rising edges (E) and ir_ock rising events (C), each saturating at 255.
REQ-025 At each ir_bck rising event in RX, slot bit = (4*E >= C and E>0), shifted MSB-first into a holding register; counters clear.
REQ-026 After IR_BITS slots: ir_dout <= holding register, state -> IDLE, ir_done=1 same clk; ir_load while not IDLE is ignored.
REQ-027 ir_load asserted in the same clk the frame completes is honoured on the following clk (IDLE seen first).
REQ-028 If aud_ock stops, modulator/demodulator state and outputs hold; if ir_bck stops, receiver waits indefinitely.

Reset
REQ-029 rst=1 clears synchronizers, acc_l, acc_r, shift registers, counts, aud_sdo=0, aud_dout_l/r=0, ir_dout=0, ir_done=0, state IDLE.
REQ-030 First clk after rst deasserts: ir_done=1; reset mid-frame discards partial frame.

Verification
REQ-031 rst pulse -> all outputs 0 during reset; ir_done=1 one clk after release.
REQ-032 din_l=din_r=0x80000000, aud_sdo looped to aud_sdi -> per channel bits 0,1,0,1...; after WIN bits per channel dout_l=dout_r=0x80000000.
REQ-033 din_l=0xFFFFFFFF, din_r=0 looped -> left bits 0 then all 1, right all 0; after WIN+1 left bits dout_l=0xFFFFFFFF, dout_r=0.
REQ-034 ir_load tied to ir_done, ir_sdi = ir_ock gated on for slots 1,0,1,1,0 -> ir_done pulses low for 5 slots+wait, ir_dout=5'b10110.
REQ-035 rst asserted during RX slot 3 -> ir_dout=0, ir_done=1 after release, next frame received correctly.
REQ-036 aud_ock frozen 20 us -> aud_sdo, aud_dout_l/r unchanged; resume -> accumulation continues from held state.
